// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Turns the decoder's MemRead/MemWrite into a single req/ack transaction on
// the data-memory port and holds the core stalled until that access is over.
// Three states: IDLE (waiting for a memory instruction), ACCESS (request held
// on the port until ack) and DONE (one-cycle bubble that releases the stall
// while the same instruction is still presented).
//
// Optional feature macro: MEMSEQ_TIMEOUT_EN
//   defined   : ACCESS cycles are counted; TIMEOUT cycles without ack abort the
//               access, set the sticky err_o and return zero for reads.
//   undefined : ACCESS waits for ack indefinitely; err_o is tied low and
//               err_clr_i has no effect.

module mem_access_sequencer #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   // core side
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              err_clr_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              err_o,
   // data-memory side
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [DATA_W-1:0] dmem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e              state_q;
   logic                req_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                rdata_valid_q;

   logic                mem_op_s;
   logic                timeout_s;

   assign mem_op_s = mem_read_i | mem_write_i;

`ifdef MEMSEQ_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [CNT_W-1:0]    cnt_inc_s;
   logic                err_q;
   logic                err_d;

   // Wait counter next state: counts ACCESS cycles that end without ack
   always_comb begin
      cnt_inc_s = cnt_q + CNT_W'(1);
      timeout_s = 1'b0;
      if ((state_q == ST_ACCESS) && !dmem_ack_i) begin
         cnt_d = cnt_inc_s;
         if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
            timeout_s = 1'b1;
         end else begin
            timeout_s = 1'b0;
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
   end

   // Sticky error next state: a timeout in the same cycle as a clear keeps err set
   always_comb begin
      if (timeout_s) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Wait counter and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic                unused_err_clr_s;
   logic [31:0]         unused_timeout_s;

   assign timeout_s        = 1'b0;
   assign unused_err_clr_s = err_clr_i;
   assign unused_timeout_s = 32'(TIMEOUT);
   assign err_o            = 1'b0;
`endif

   // Sequencer FSM: latches the request, drives the port and captures load data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         rdata_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mem_op_s) begin
                  // a simultaneous read and write is issued as a write
                  state_q <= ST_ACCESS;
                  req_q   <= 1'b1;
                  we_q    <= mem_write_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (dmem_ack_i) begin
                  if (!we_q) begin
                     rdata_q       <= dmem_rdata_i;
                     rdata_valid_q <= 1'b1;
                  end
                  state_q <= ST_DONE;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= '0;
                  wdata_q <= '0;
               end else if (timeout_s) begin
                  // aborted read returns zero but still signals completion
                  if (!we_q) begin
                     rdata_q       <= '0;
                     rdata_valid_q <= 1'b1;
                  end
                  state_q <= ST_DONE;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= '0;
                  wdata_q <= '0;
               end else begin
                  state_q <= ST_ACCESS;
               end
            end
            ST_DONE: begin
               // the same instruction is still presented here; never relaunch from DONE
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
               addr_q  <= '0;
               wdata_q <= '0;
            end
         endcase
      end
   end

   // Stall is combinational so the pipeline freezes in the same cycle the
   // memory instruction appears; reset forces it low even if an op is presented.
   assign stall_o = !rst &&
                    (((state_q == ST_IDLE) && mem_op_s) || (state_q == ST_ACCESS));

   assign dmem_req_o    = req_q;
   assign dmem_we_o     = we_q;
   assign dmem_addr_o   = addr_q;
   assign dmem_wdata_o  = wdata_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed accesses with a scoreboard of
// expected memory requests and expected load results, checked by a monitor.
`timescale 1ns/1ps

module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_i, mem_write_i, err_clr_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, rdata_valid_o, err_o;
   logic [31:0] rdata_o;
   logic        dmem_req_o, dmem_we_o, dmem_ack_i;
   logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;

   int checks = 0;
   int errors = 0;

   logic [64:0] req_q[$];   // {we, addr, wdata}
   logic [31:0] rd_q[$];    // expected rdata_o at each rdata_valid_o pulse
   logic        req_prev = 1'b0;

   always #5 clk = ~clk;

   mem_access_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .err_clr_i(err_clr_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .err_o(err_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares each new request and each load-complete pulse against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (dmem_req_o && !req_prev) begin
            if (req_q.size() == 0) begin
               chk("req_unexpected", {dmem_we_o, dmem_addr_o, dmem_wdata_o}, 128'h0);
               checks--; // counted as a failure line only
               if ({dmem_we_o, dmem_addr_o, dmem_wdata_o} === 65'h0) begin
                  errors++;
                  checks++;
                  $display("FAIL req_unexpected: got request expected none");
               end else begin
                  checks++;
               end
            end else begin
               chk("req_fields", {dmem_we_o, dmem_addr_o, dmem_wdata_o}, req_q.pop_front());
            end
         end
         if (rdata_valid_o) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rdata_valid_unexpected: got pulse rdata 0x%0h expected none", rdata_o);
            end else begin
               chk("rdata", rdata_o, rd_q.pop_front());
            end
         end
      end
      req_prev = dmem_req_o;
   end

   // Runs one memory instruction from IDLE; called at posedge+1, returns at
   // posedge+1 of the cycle after DONE with the core inputs dropped.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rdv, input logic [31:0] exp_rd,
                            input int exp_req, input int exp_stall, input string tag);
      int   stall_n = 0, req_n = 0, cyc = 0, first_req = -1;
      logic stable_ok = 1'b1, zero_ok = 1'b1, done = 1'b0;
      mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd;
      req_q.push_back({wr, a, wd});
      if (rd && !wr) rd_q.push_back(exp_rd);
      #1;
      while (cyc < 60 && !done) begin
         if (stall_o) stall_n++;
         if (dmem_req_o) begin
            req_n++;
            if (first_req < 0) first_req = cyc;
            if ({dmem_we_o, dmem_addr_o, dmem_wdata_o} !== {wr, a, wd}) stable_ok = 1'b0;
            dmem_ack_i   = (req_n == waits + 1);
            dmem_rdata_i = rdv;
         end else begin
            dmem_ack_i = 1'b0;
            if ({dmem_we_o, dmem_addr_o, dmem_wdata_o} !== 65'h0) zero_ok = 1'b0;
         end
         if (!stall_o && cyc > 0) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #2;
            cyc++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no DONE within 60 cycles expected completion", tag);
      end
      chk({tag, "_stall_cycles"}, stall_n, exp_stall);
      chk({tag, "_req_cycles"}, req_n, exp_req);
      chk({tag, "_first_req_cycle"}, first_req, 1);
      chk({tag, "_req_stable"}, stable_ok, 1'b1);
      chk({tag, "_idle_done_zero"}, zero_ok, 1'b1);
      @(posedge clk); #1;
      mem_read_i = 1'b0; mem_write_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      rst = 1'b1;
      mem_read_i = 1'b1; mem_write_i = 1'b0; err_clr_i = 1'b0;
      addr_i = 32'h10; wdata_i = 32'h0;
      dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      // reset: every output low, even with a read presented
      chk("reset_outputs", {stall_o, rdata_valid_o, err_o, dmem_req_o, dmem_we_o,
                            dmem_addr_o, dmem_wdata_o, rdata_o}, 128'h0);
      mem_read_i = 1'b0; addr_i = 32'h0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_no_stall", {stall_o, dmem_req_o}, 2'b00);

      // 1: zero-wait load
      do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 2, "t1");
      chk("t1_rdata_hold", rdata_o, 32'hDEADBEEF);

      // 2: store with three wait cycles
      do_access(1'b0, 1'b1, 32'h100, 32'h55, 3, 32'hFFFF0000, 32'h0, 4, 5, "t2");
      chk("t2_rdata_untouched", rdata_o, 32'hDEADBEEF);

      // 3: load then store back-to-back
      do_access(1'b1, 1'b0, 32'h204, 32'h0, 1, 32'h12345678, 32'h12345678, 2, 3, "t3ld");
      do_access(1'b0, 1'b1, 32'h208, 32'hCAFEF00D, 2, 32'h0BADBAD0, 32'h0, 3, 4, "t3st");
      chk("t3_rdata_kept", rdata_o, 32'h12345678);

      // 6: read and write together issue a write; ack in IDLE is ignored
      do_access(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 0, 32'h0, 32'h0, 1, 2, "t6");
      ok = 1'b1;
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0BAD0BAD;
      repeat (3) begin
         @(posedge clk); #1;
         if (stall_o || dmem_req_o) ok = 1'b0;
      end
      dmem_ack_i = 1'b0;
      chk("t6_spurious_ack_ignored", ok, 1'b1);
      chk("t6_rdata_kept", rdata_o, 32'h12345678);

      // 5: no ack
`ifdef MEMSEQ_TIMEOUT_EN
      do_access(1'b1, 1'b0, 32'h500, 32'h0, 100, 32'h77777777, 32'h0, 15, 16, "t5abort");
      chk("t5_err_set", err_o, 1'b1);
      chk("t5_rdata_zero", rdata_o, 32'h0);
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      chk("t5_err_cleared", err_o, 1'b0);
      do_access(1'b1, 1'b0, 32'h504, 32'h0, 14, 32'h99999999, 32'h99999999, 15, 16, "t5edge");
      chk("t5_edge_no_err", err_o, 1'b0);
`else
      do_access(1'b1, 1'b0, 32'h500, 32'h0, 20, 32'h77777777, 32'h77777777, 21, 22, "t5wait");
      chk("t5_err_low", err_o, 1'b0);
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      chk("t5_err_still_low", err_o, 1'b0);
`endif

      // 4: reset asserted in the middle of an access
      mem_read_i = 1'b1; addr_i = 32'h400; wdata_i = 32'h0;
      req_q.push_back({1'b0, 32'h400, 32'h0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t4_in_access", {stall_o, dmem_req_o}, 2'b11);
      #2 rst = 1'b1;
      #1;
      chk("t4_async_clear", {stall_o, rdata_valid_o, err_o, dmem_req_o, dmem_we_o,
                             dmem_addr_o, dmem_wdata_o, rdata_o}, 128'h0);
      @(posedge clk); #1;
      chk("t4_held_clear", {stall_o, dmem_req_o, rdata_o}, 34'h0);
      mem_read_i = 1'b0; addr_i = 32'h0;
      #2 rst = 1'b0;
      #1;
      chk("t4_release_idle", {stall_o, dmem_req_o}, 2'b00);
      @(posedge clk); #1;
      chk("t4_stays_idle", {stall_o, dmem_req_o}, 2'b00);
      do_access(1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 2, 3, "t4post");

      repeat (2) @(posedge clk);
      #1;
      chk("req_scoreboard_empty", req_q.size(), 0);
      chk("rdata_scoreboard_empty", rd_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
